// File: rtl/frame_dispatch_queue_pkg.sv
// Shared types and helpers for the frame dispatch queue.
// Frame layout is {SFD, dst, src, payload}, MSB first.
package frame_dispatch_queue_pkg;

  localparam logic [3:0] SFD = 4'b0101;
  localparam logic [3:0] MAC_BASE_DEF = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  function automatic int frame_w(int aw, int dw);
    return 4 + 2 * aw + dw;
  endfunction

  function automatic int port_of(int src, int base);
    return src - base;
  endfunction

endpackage

// File: rtl/frame_dispatch_queue_if.sv
// Host-side and transmitter-side bundle of the dispatch queue.
// master drives adds/control, slave is the queue itself.
interface frame_dispatch_queue_if #(
  parameter int DEPTH     = 8,
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4
);
  import frame_dispatch_queue_pkg::*;

  localparam int FW = frame_w(ADDR_W, DATA_W);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    add_valid;
  logic [ADDR_W-1:0]       dst_addr;
  logic [ADDR_W-1:0]       src_addr;
  logic [DATA_W-1:0]       payload;
  logic                    send_start;
  logic                    flush;
  logic [NUM_PORTS-1:0]    tx_busy;
  logic [NUM_PORTS*FW-1:0] frame_to_send;
  logic [NUM_PORTS-1:0]    frame_tx_valid;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    busy;
  logic [7:0]              drop_cnt;
  logic                    err_src;

  modport master (
    output add_valid, dst_addr, src_addr, payload,
    output send_start, flush, tx_busy,
    input  frame_to_send, frame_tx_valid, count,
    input  full, empty, busy, drop_cnt, err_src
  );

  modport slave (
    input  add_valid, dst_addr, src_addr, payload,
    input  send_start, flush, tx_busy,
    output frame_to_send, frame_tx_valid, count,
    output full, empty, busy, drop_cnt, err_src
  );

endinterface

// File: rtl/frame_fifo.sv
// In-order frame store with same-cycle push+pop and flush.
// Occupancy is an up/down counter, pointers wrap modulo DEPTH.
module frame_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wr_data,
  input  logic                   pop,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty && !flush;
    push_ok  = push && (!full || pop_ok) && !flush;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/frame_dispatch_queue.sv
// Builds frames from user fields, queues them in order and
// dispatches one per issue slot to per-port transmitters.
module frame_dispatch_queue
  import frame_dispatch_queue_pkg::*;
#(
  parameter int                DEPTH      = 8,
  parameter int                NUM_PORTS  = 4,
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 4,
  parameter logic [ADDR_W-1:0] MAC_BASE   = ADDR_W'(MAC_BASE_DEF),
  parameter int                MODE       = 0,
  parameter int                GAP_CYCLES = 20
) (
  input logic                   clk,
  input logic                   rst_n,
  frame_dispatch_queue_if.slave bus
);

  localparam int FW = frame_w(ADDR_W, DATA_W);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e               state_q, state_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [FW-1:0]        fts_q [NUM_PORTS];
  logic [FW-1:0]        fts_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] ftv_q, ftv_d;
  logic [7:0]           drop_q, drop_d;
  logic                 err_q, err_d;

  int                   idx;
  logic                 src_ok;
  logic [PW-1:0]        src_port;
  logic                 add_ok, push, pop, drop;
  logic [PW+FW-1:0]     wr_data, head;
  logic [PW-1:0]        head_port;
  logic [FW-1:0]        head_frame;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;

  always_comb begin
    idx      = port_of(int'(bus.src_addr), int'(MAC_BASE));
    src_ok   = (idx >= 0) && (idx < NUM_PORTS);
    src_port = idx[PW-1:0];
  end

  assign wr_data = {src_port, SFD, bus.dst_addr,
                    bus.src_addr, bus.payload};
  assign head_port  = head[FW +: PW];
  assign head_frame = head[FW-1:0];

  frame_fifo #(
    .DEPTH (DEPTH),
    .W     (PW + FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.flush),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Flush wins over everything: no pop, no strobe, no add.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    fts_d   = fts_q;
    ftv_d   = '0;
    pop     = 1'b0;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.send_start && !fifo_empty) state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if (fifo_empty) begin
            state_d = S_IDLE;
          end else if (!bus.tx_busy[head_port]) begin
            pop               = 1'b1;
            fts_d[head_port]  = head_frame;
            ftv_d[head_port]  = 1'b1;
            gap_d             = GW'(GAP_CYCLES - 1);
            state_d           = S_WAIT;
          end
        end
        S_WAIT: begin
          if (gap_q == '0) begin
            state_d = (MODE == 0) ? S_ISSUE : S_IDLE;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    add_ok = bus.add_valid && !bus.flush;
    push   = add_ok && src_ok && (!fifo_full || pop);
    drop   = add_ok && (!src_ok || (fifo_full && !pop));
    err_d  = add_ok && !src_ok;
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      fts_q   <= '{default: '0};
      ftv_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      fts_q   <= fts_d;
      ftv_q   <= ftv_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    assign bus.frame_to_send[p*FW +: FW] = fts_q[p];
  end

  assign bus.frame_tx_valid = ftv_q;
  assign bus.count          = fifo_count;
  assign bus.full           = fifo_full;
  assign bus.empty          = fifo_empty;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.drop_cnt       = drop_q;
  assign bus.err_src        = err_q;

endmodule

// File: doc/frame_dispatch_queue.md
Name: frame_dispatch_queue

Overview:
- Parametrised successor to the top-level pending-frame queue: builds frames from user fields, buffers them in order, and dispatches them to per-port EndDevice transmitters.
- Adds ordered FIFO storage of configurable depth and source-port count.
- Adds burst or single-step dispatch, per-port busy back-pressure and a minimum inter-frame gap.
- Adds overflow/invalid-source accounting and flush.
- Fixes the old same-cycle overwrite: at most one frame is issued per cycle.

Parameters:
- DEPTH, 8, queue entries (power of two, >=2)
- NUM_PORTS, 4, number of EndDevice ports (2..16)
- ADDR_W, 4, MAC address width
- DATA_W, 4, payload width
- MAC_BASE, 4'hA, MAC of port 0; port p has MAC MAC_BASE+p
- MODE, 0, 0 = burst (drain whole queue per send_start), 1 = single (one frame per send_start)
- GAP_CYCLES, 20, minimum idle cycles between successive issues (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- add_valid  in  1  one-cycle pulse: enqueue frame from fields below
- dst_addr  in  ADDR_W  destination MAC
- src_addr  in  ADDR_W  source MAC; selects port
- payload  in  DATA_W  payload nibble(s)
- send_start  in  1  one-cycle pulse: begin dispatch
- flush  in  1  synchronous queue clear
- tx_busy  in  NUM_PORTS  per-port transmitter busy
- frame_to_send  out  NUM_PORTS*FRAME_W  port p occupies slice [p*FRAME_W +: FRAME_W]; FRAME_W = 4+2*ADDR_W+DATA_W
- frame_tx_valid  out  NUM_PORTS  one-cycle issue strobe per port
- count  out  clog2(DEPTH)+1  current occupancy
- full, empty  out  1  queue status
- busy  out  1  FSM not IDLE
- drop_cnt  out  8  saturating count of rejected adds
- err_src  out  1  one-cycle pulse: add rejected for bad src_addr

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty; count=0; empty=1; full=0; busy=0; drop_cnt=0; err_src=0.
  - frame_tx_valid=0; all frame_to_send slices=0; FSM IDLE; gap counter=0.
- Frame format, MSB first: {SFD=4'b0101, dst_addr, src_addr, payload}, captured on the add_valid edge.
- Port index: src_addr-MAC_BASE.
  - If src_addr<MAC_BASE or the index is >=NUM_PORTS: reject, pulse err_src next cycle, increment drop_cnt. There is no default-to-port-0.
- Enqueue:
  - Accepted if !full, or if a pop occurs in the same cycle.
  - Otherwise the add is dropped and drop_cnt increments.
  - drop_cnt saturates at 255.
- Simultaneous push and pop: both take effect and count is unchanged.
- FSM:
  - IDLE:
    - send_start && !empty -> ISSUE.
    - send_start && empty -> stay IDLE, no strobe.
  - ISSUE:
    - If empty -> IDLE.
    - Else if tx_busy[head_port]=0:
      - Pop the head entry.
      - Load frame_to_send[head_port].
      - Assert frame_tx_valid[head_port] for exactly 1 cycle.
      - Load gap counter with GAP_CYCLES-1.
      - -> WAIT.
    - Else stall in ISSUE. Head-of-line blocking is intentional: order is strictly preserved.
  - WAIT:
    - Decrement the gap counter.
    - At 0: MODE=0 -> ISSUE; MODE=1 -> IDLE.
- Latency: send_start sampled at edge N -> ISSUE from edge N+1 -> frame_tx_valid high after edge N+2, if the port is free.
- Issue spacing: consecutive strobes are >= GAP_CYCLES+1 cycles apart.
- send_start while busy=1 is ignored.
- Adds are accepted in any state. Frames added during a burst drain are drained in the same burst.
- frame_to_send slices hold their last value until overwritten; only frame_tx_valid is pulsed.
- flush:
  - Highest priority after reset.
  - Empties the FIFO, returns FSM to IDLE and clears frame_tx_valid.
  - A same-cycle add_valid is discarded and not counted as a drop.
- At most one bit of frame_tx_valid is high per cycle.
- Pointers wrap modulo DEPTH. count is derived from a push/pop up-down counter, not from pointer difference.

Decomposition:
- Shared include frame_defs.vh holds:
  - SFD constant
  - default MAC_BASE
  - FRAME_W macro
  - port-index extraction macro (also used by EndDevice/L2_Switch)
- One sub-module, frame_fifo: synchronous FIFO with push/pop, full/empty/count, same-cycle push+pop.
  - Width is FRAME_W + port index width.
- FSM, gap counter, demux and drop logic live in frame_dispatch_queue.

Test Plan:
- Reset and issue:
  - Stimulus: reset; add (dst=B, src=A, pl=3); send_start.
  - Response: frame_to_send[0]=16'h5BA3; frame_tx_valid=4'b0001 for 1 cycle, 2 cycles after send_start; count goes 1->0.
- Burst ordering and gap (MODE=0, GAP_CYCLES=20):
  - Stimulus: add 3 frames all src=C with payloads 1,2,3; send_start.
  - Response: three strobes on port 2 with payloads 1,2,3 in that order, spaced 21 cycles; busy falls after the last.
- Overflow (DEPTH=8):
  - Stimulus: 10 adds.
  - Response: count=8, full=1, drop_cnt=2.
  - Stimulus: add+pop in the same cycle while full.
  - Response: accepted; count stays 8.
- Invalid source:
  - Stimulus: add with src=4'h3.
  - Response: err_src pulse; drop_cnt+1; count unchanged.
- Back-pressure:
  - Stimulus: tx_busy[1]=1 with head frame src=B and a later frame src=A.
  - Response: no strobe while busy. Release after 50 cycles -> B issued first, then A after the gap.
- Flush/reset mid-drain:
  - Stimulus: flush during WAIT with 4 frames queued.
  - Response: empty=1, busy=0 next cycle, no further strobes.
  - Stimulus: async rst_n low mid-ISSUE.
  - Response: all outputs at reset values immediately.
